// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer block.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    RUN   = 3'd1,
    STALL = 3'd2,
    FLUSH = 3'd3,
    HALT  = 3'd4
  } seqState_t;

  localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control bundle between the hazard/branch logic and the fetch stage.
// With FETCH_SEQ_PERF_EN defined, the bundle also carries the two perf counters.
interface fetch_sequencer_if #(
  parameter int PC_WIDTH = 32
);

  logic                stall;
  logic                branchTaken;
  logic [PC_WIDTH-1:0] branchTarget;
  logic                haltDetected;
  logic                resume;
  logic                fetchEnable;
  logic                pcSelector;
  logic [PC_WIDTH-1:0] newPC;
  logic                flushIFID;
  logic                halted;
  logic [2:0]          state;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0]         stallCount;
  logic [31:0]         flushCount;

  modport master (
    output stall, branchTaken, branchTarget, haltDetected, resume,
    input  fetchEnable, pcSelector, newPC, flushIFID, halted, state,
    input  stallCount, flushCount
  );

  modport slave (
    input  stall, branchTaken, branchTarget, haltDetected, resume,
    output fetchEnable, pcSelector, newPC, flushIFID, halted, state,
    output stallCount, flushCount
  );
`else
  modport master (
    output stall, branchTaken, branchTarget, haltDetected, resume,
    input  fetchEnable, pcSelector, newPC, flushIFID, halted, state
  );

  modport slave (
    input  stall, branchTaken, branchTarget, haltDetected, resume,
    output fetchEnable, pcSelector, newPC, flushIFID, halted, state
  );
`endif

endinterface

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter used for the fetch sequencer perf counters.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count qualifying cycles, sticking at all-ones once reached.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control FSM: boot from the reset vector, stalls, branch
// redirects with a timed IF/ID flush window, and halt/resume.
// Optional perf counters are built when FETCH_SEQ_PERF_EN is defined.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  FLUSH_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  fetch_sequencer_if.slave  bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam seqState_t REDIRECT_STATE = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  seqState_t               stateReg;
  seqState_t               stateNext;
  logic [FLUSH_CNT_W-1:0]  flushCnt;
  logic [FLUSH_CNT_W-1:0]  flushCntNext;
  logic [PC_WIDTH-1:0]     pcHold;
  logic [PC_WIDTH-1:0]     pcNext;
  logic                    fetchEn;
  logic                    pcSel;
  logic                    flushOut;
  logic                    haltOut;

  // State, flush counter and redirect-address hold; reset drops any pending flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateReg <= BOOT;
      flushCnt <= '0;
      pcHold   <= RESET_VECTOR;
    end else begin
      stateReg <= stateNext;
      flushCnt <= flushCntNext;
      pcHold   <= pcNext;
    end
  end

  // Next-state and output decode from current state plus this cycle's inputs.
  always_comb begin
    stateNext    = stateReg;
    flushCntNext = flushCnt;
    pcNext       = pcHold;
    fetchEn      = 1'b0;
    pcSel        = 1'b0;
    flushOut     = 1'b0;
    haltOut      = 1'b0;
    case (stateReg)
      BOOT: begin
        fetchEn   = reset;
        pcSel     = 1'b1;
        flushOut  = 1'b1;
        pcNext    = RESET_VECTOR;
        stateNext = RUN;
      end
      RUN, STALL: begin
        if (bus.branchTaken) begin
          fetchEn      = 1'b1;
          pcSel        = 1'b1;
          flushOut     = 1'b1;
          pcNext       = bus.branchTarget;
          flushCntNext = FLUSH_LOAD;
          stateNext    = REDIRECT_STATE;
        end else if (bus.haltDetected) begin
          flushOut  = 1'b1;
          stateNext = HALT;
        end else if (bus.stall) begin
          stateNext = STALL;
        end else if (stateReg == RUN) begin
          fetchEn = 1'b1;
        end else begin
          stateNext = RUN;
        end
      end
      FLUSH: begin
        fetchEn  = !bus.stall;
        flushOut = 1'b1;
        if (flushCnt <= FLUSH_CNT_W'(1)) begin
          flushCntNext = '0;
          stateNext    = RUN;
        end else begin
          flushCntNext = flushCnt - FLUSH_CNT_W'(1);
        end
      end
      HALT: begin
        haltOut = 1'b1;
        if (bus.resume) begin
          stateNext = RUN;
        end
      end
      default: begin
        stateNext = BOOT;
      end
    endcase
  end

  assign bus.fetchEnable = fetchEn;
  assign bus.pcSelector  = pcSel;
  assign bus.newPC       = pcNext;
  assign bus.flushIFID   = flushOut;
  assign bus.halted      = haltOut;
  assign bus.state       = stateReg;

`ifdef FETCH_SEQ_PERF_EN
  logic stallInc;
  logic flushInc;

  assign stallInc = (stateReg == STALL) && !fetchEn;
  assign flushInc = ((stateReg == RUN) || (stateReg == FLUSH)) && flushOut;

  sat_counter #(.WIDTH(32)) uStallCount (
    .clock (clock),
    .reset (reset),
    .inc   (stallInc),
    .count (bus.stallCount)
  );

  sat_counter #(.WIDTH(32)) uFlushCount (
    .clock (clock),
    .reset (reset),
    .inc   (flushInc),
    .count (bus.flushCount)
  );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: the driver pushes hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_fetch_sequencer;
  import fetch_seq_pkg::*;

  localparam logic [31:0] RV = 32'h40;

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic        fe;
    logic        sel;
    logic [31:0] pc;
    logic        fl;
    logic        hl;
  } exp_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  exp_t expQ[$];

  fetch_sequencer_if #(.PC_WIDTH(32)) bus ();

  fetch_sequencer #(
    .PC_WIDTH     (32),
    .RESET_VECTOR (RV),
    .FLUSH_CYCLES (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one expectation against the DUT outputs now.
  task automatic checkOutput(input exp_t e);
    checks++;
    if ({bus.state, bus.fetchEnable, bus.pcSelector, bus.newPC, bus.flushIFID, bus.halted}
        !== {e.st, e.fe, e.sel, e.pc, e.fl, e.hl}) begin
      errors++;
      $display("[TB] FAIL %s: got state=%0d fe=%b sel=%b newPC=%h flush=%b halted=%b, required state=%0d fe=%b sel=%b newPC=%h flush=%b halted=%b",
               e.name, bus.state, bus.fetchEnable, bus.pcSelector, bus.newPC, bus.flushIFID, bus.halted,
               e.st, e.fe, e.sel, e.pc, e.fl, e.hl);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, advance a cycle.
  task automatic applyStimulus(input string name, input logic s, input logic b,
                               input logic [31:0] t, input logic h, input logic r,
                               input logic [2:0] st, input logic fe, input logic sel,
                               input logic [31:0] pc, input logic fl, input logic hl);
    exp_t e;
    bus.stall        = s;
    bus.branchTaken  = b;
    bus.branchTarget = t;
    bus.haltDetected = h;
    bus.resume       = r;
    e = '{name, st, fe, sel, pc, fl, hl};
    expQ.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, checked mid-cycle.
  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  initial begin
    exp_t e;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.branchTaken = 1'b0;
    bus.branchTarget = '0;
    bus.haltDetected = 1'b0;
    bus.resume = 1'b0;
    #2;
    e = '{"reset_state", BOOT, 1'b0, 1'b1, RV, 1'b1, 1'b0};
    checkOutput(e);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;

    //            name          s  b  target     h  r  state  fe sel newPC      fl hl
    applyStimulus("boot",       0, 0, 32'h0,     0, 0, BOOT,  1, 1, RV,        1, 0);
    applyStimulus("run1",       0, 0, 32'h0,     0, 0, RUN,   1, 0, RV,        0, 0);
    applyStimulus("run2",       0, 0, 32'h0,     0, 0, RUN,   1, 0, RV,        0, 0);
    applyStimulus("br100",      0, 1, 32'h100,   0, 0, RUN,   1, 1, 32'h100,   1, 0);
    applyStimulus("flush100",   0, 0, 32'h0,     0, 0, FLUSH, 1, 0, 32'h100,   1, 0);
    applyStimulus("run_aft100", 0, 0, 32'h0,     0, 0, RUN,   1, 0, 32'h100,   0, 0);
    applyStimulus("stall1",     1, 0, 32'h0,     0, 0, RUN,   0, 0, 32'h100,   0, 0);
    applyStimulus("stall2_br",  1, 1, 32'h200,   0, 0, STALL, 1, 1, 32'h200,   1, 0);
    applyStimulus("stall3_fl",  1, 0, 32'h0,     0, 0, FLUSH, 0, 0, 32'h200,   1, 0);
    applyStimulus("run_aft200", 0, 0, 32'h0,     0, 0, RUN,   1, 0, 32'h200,   0, 0);
    applyStimulus("br300",      0, 1, 32'h300,   0, 0, RUN,   1, 1, 32'h300,   1, 0);
    applyStimulus("flush_ign",  0, 1, 32'h400,   1, 0, FLUSH, 1, 0, 32'h300,   1, 0);
    applyStimulus("run_aft300", 0, 0, 32'h0,     0, 0, RUN,   1, 0, 32'h300,   0, 0);
    applyStimulus("halt_stall", 1, 0, 32'h0,     1, 0, RUN,   0, 0, 32'h300,   1, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus("halt_idle", 0, 0, 32'h0,   0, 0, HALT,  0, 0, 32'h300,   0, 1);
    end
    applyStimulus("resume",     0, 0, 32'h0,     0, 1, HALT,  0, 0, 32'h300,   0, 1);
    applyStimulus("run_resume", 0, 0, 32'h0,     0, 0, RUN,   1, 0, 32'h300,   0, 0);
    applyStimulus("stallA",     1, 0, 32'h0,     0, 0, RUN,   0, 0, 32'h300,   0, 0);
    applyStimulus("stallB",     1, 0, 32'h0,     0, 0, STALL, 0, 0, 32'h300,   0, 0);
    applyStimulus("stall_rel",  0, 0, 32'h0,     0, 0, STALL, 0, 0, 32'h300,   0, 0);
    applyStimulus("run_rel",    0, 0, 32'h0,     0, 0, RUN,   1, 0, 32'h300,   0, 0);
    applyStimulus("br500",      0, 1, 32'h500,   0, 0, RUN,   1, 1, 32'h500,   1, 0);

    // Now mid-FLUSH: drop reset between edges and check before the next edge.
    bus.branchTaken = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    e = '{"async_reset", BOOT, 1'b0, 1'b1, RV, 1'b1, 1'b0};
    checkOutput(e);
`ifdef FETCH_SEQ_PERF_EN
    checks++;
    if ((bus.stallCount !== 32'd0) || (bus.flushCount !== 32'd0)) begin
      errors++;
      $display("[TB] FAIL perf_reset: got stallCount=%0d flushCount=%0d, required 0 and 0",
               bus.stallCount, bus.flushCount);
    end
`endif
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    applyStimulus("reboot",     0, 0, 32'h0,     0, 0, BOOT,  1, 1, RV,        1, 0);
    applyStimulus("rerun",      0, 0, 32'h0,     0, 0, RUN,   1, 0, RV,        0, 0);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(negedge clock);
      #1;
    end
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations, required 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
